// File: rtl/matrix_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_controller
// Brief    : Column-scan sequencer for a dot-matrix panel with per-slot
//            blanking and frame-boundary req/ack frame loading.
// Revision : 1.0  initial release
// ============================================================================
module matrix_scan_controller #(
    parameter int NUM_COLS = 5,
    parameter int NUM_ROWS = 7,
    parameter int DIV      = 4,
    parameter int BLANK    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_COLS*NUM_ROWS-1:0] frame_data,
    input  logic                         load_req,
    output logic                         load_ack,
    output logic [2:0]                   col_sel,
    output logic [NUM_COLS-1:0]          col_en,
    output logic [NUM_ROWS-1:0]          row_out,
    output logic                         frame_start
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] c_DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0] c_BLANK    = CW'(BLANK);
    localparam logic [2:0]    c_LAST_COL = 3'(NUM_COLS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BLANK = 2'd1;
    localparam logic [1:0] c_ST_SHOW  = 2'd2;

    logic [1:0]                   r_state;
    logic [2:0]                   r_col;
    logic [CW-1:0]                r_cnt;
    logic [NUM_COLS*NUM_ROWS-1:0] r_buf;

    logic                         r_load_ack;
    logic [2:0]                   r_col_sel;
    logic [NUM_COLS-1:0]          r_col_en;
    logic [NUM_ROWS-1:0]          r_row_out;
    logic                         r_frame_start;

    logic [1:0]                   w_nxt_state;
    logic [2:0]                   w_nxt_col;
    logic [CW-1:0]                w_nxt_cnt;
    logic                         w_load;
    logic [NUM_COLS*NUM_ROWS-1:0] w_nxt_buf;
    logic [NUM_ROWS-1:0]          w_row;
    logic [NUM_COLS-1:0]          w_onehot;
    logic                         w_show;
    logic                         w_run;

    // Next-state: a load is only accepted when idle or on the edge that
    // re-enters column 0 slot 0, so a frame is never torn mid-scan.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_col   = r_col;
        w_nxt_cnt   = r_cnt;
        w_load      = 1'b0;
        if (!enable) begin
            w_nxt_state = c_ST_IDLE;
            w_nxt_col   = 3'd0;
            w_nxt_cnt   = '0;
            w_load      = (r_state == c_ST_IDLE) && load_req;
        end else if (r_state == c_ST_IDLE) begin
            w_nxt_col   = 3'd0;
            w_nxt_cnt   = '0;
            w_nxt_state = (BLANK > 0) ? c_ST_BLANK : c_ST_SHOW;
            w_load      = load_req;
        end else begin
            if (r_cnt == c_DIV_M1) begin
                w_nxt_cnt = '0;
                w_nxt_col = (r_col == c_LAST_COL) ? 3'd0 : r_col + 3'd1;
                w_load    = load_req && (r_col == c_LAST_COL);
            end else begin
                w_nxt_cnt = r_cnt + CW'(1);
            end
            w_nxt_state = ((BLANK > 0) && (w_nxt_cnt < c_BLANK)) ? c_ST_BLANK : c_ST_SHOW;
        end
    end

    assign w_nxt_buf = w_load ? frame_data : r_buf;
    assign w_show    = (w_nxt_state == c_ST_SHOW);
    assign w_run     = (w_nxt_state != c_ST_IDLE);

    // Outputs are registered from next-state values so they line up with
    // the state they describe.
    always_comb begin
        w_row    = '0;
        w_onehot = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (w_nxt_col == 3'(c)) begin
                w_row       = w_nxt_buf[c*NUM_ROWS +: NUM_ROWS];
                w_onehot[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_col         <= 3'd0;
            r_cnt         <= '0;
            r_buf         <= '0;
            r_load_ack    <= 1'b0;
            r_col_sel     <= 3'd0;
            r_col_en      <= '0;
            r_row_out     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_col         <= w_nxt_col;
            r_cnt         <= w_nxt_cnt;
            r_buf         <= w_nxt_buf;
            r_load_ack    <= w_load;
            r_col_sel     <= w_run ? w_nxt_col : 3'd0;
            r_col_en      <= w_show ? w_onehot : '0;
            r_row_out     <= w_show ? w_row : '0;
            r_frame_start <= w_run && (w_nxt_col == 3'd0) && (w_nxt_cnt == '0);
        end
    end

    assign load_ack    = r_load_ack;
    assign col_sel     = r_col_sel;
    assign col_en      = r_col_en;
    assign row_out     = r_row_out;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
